mod_n_stream_checker: RTL

//   Parametrised successor to the fixed divide-by-3 serial checker.

---
 rtl/mod_n_stream_checker_if.sv | 45 ++++
 rtl/mod_n_stream_checker.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mod_n_stream_checker_if.sv
// ---------------------------------------------------------------------------
// mod_n_stream_checker_if
//   Bundles the configuration, serial-input, abort and result signals of the
//   mod-N stream checker.
//   master : bit source / result collector side (drives cfg, abort, in_*)
//   slave  : checker side (drives cfg_ready, in_ready, rem/div/res/err)
//   Signals:
//     cfg_valid, cfg_divisor[DIV_W], cfg_len[LEN_W], cfg_ready : config handshake
//     abort                                                    : frame cancel
//     in_valid, in_bit, in_ready                               : serial bits
//     rem_now[DIV_W], div_now                                  : running status
//     res_valid, res_rem[DIV_W], res_div                       : frame result
//     err_cfg                                                  : config rejected
// ---------------------------------------------------------------------------
interface mod_n_stream_checker_if #(
   parameter int DIV_W = 8,
   parameter int LEN_W = 6
);
   logic             cfg_valid;
   logic [DIV_W-1:0] cfg_divisor;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_ready;
   logic             abort;
   logic             in_valid;
   logic             in_bit;
   logic             in_ready;
   logic [DIV_W-1:0] rem_now;
   logic             div_now;
   logic             res_valid;
   logic [DIV_W-1:0] res_rem;
   logic             res_div;
   logic             err_cfg;

   modport master (
      output cfg_valid, cfg_divisor, cfg_len, abort, in_valid, in_bit,
      input  cfg_ready, in_ready, rem_now, div_now, res_valid, res_rem,
             res_div, err_cfg
   );

   modport slave (
      input  cfg_valid, cfg_divisor, cfg_len, abort, in_valid, in_bit,
      output cfg_ready, in_ready, rem_now, div_now, res_valid, res_rem,
             res_div, err_cfg
   );
endinterface

// File: rtl/mod_n_stream_checker.sv
// ---------------------------------------------------------------------------
// mod_n_stream_checker
//   Accepts a runtime divisor D and frame length L, then consumes L serial
//   bits MSB-first, tracking (value mod D). At frame end it pulses res_valid
//   with the final remainder and a divisible flag.
//   Ports:
//     clk   : sole clock, all state changes on posedge
//     rst_n : asynchronous active-low reset
//     s_if  : slave side of mod_n_stream_checker_if (cfg handshake, serial
//             bits, abort, running remainder, result, config error)
// ---------------------------------------------------------------------------
module mod_n_stream_checker #(
   parameter int DIV_W = 8,
   parameter int LEN_W = 6
) (
   input  logic                         clk,
   input  logic                         rst_n,
   mod_n_stream_checker_if.slave        s_if
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [DIV_W-1:0] r_div;
   logic [DIV_W-1:0] r_rem;
   logic [DIV_W-1:0] r_res_rem;
   logic             r_res_div;
   logic             r_err_cfg;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] w_cnt_nxt;
   logic [DIV_W-1:0] w_rem_nxt;
   logic [DIV_W:0]   w_sum;
   logic             w_cfg_ok;
   logic             w_cfg_take;
   logic             w_cfg_bad;
   logic             w_last;

   // Config qualification and end-of-frame detection
   always_comb begin
      w_cfg_ok   = (s_if.cfg_divisor != {DIV_W{1'b0}}) &&
                   (s_if.cfg_len != {LEN_W{1'b0}});
      w_cfg_take = (r_state == S_IDLE) && s_if.cfg_valid && w_cfg_ok;
      w_cfg_bad  = (r_state == S_IDLE) && s_if.cfg_valid && !w_cfg_ok;
      // r_cnt never exceeds L-1 in RUN, so the increment cannot wrap.
      w_cnt_nxt  = r_cnt + LEN_W'(1);
      w_last     = (w_cnt_nxt == r_len);
   end

   // Remainder step: since rem < D, 2*rem+bit < 2D and a single conditional
   // subtract completes the modulo. The compare uses the full DIV_W+1-bit
   // sum; the subtract can be done in DIV_W bits because the true result
   // always fits and the dropped carry cancels out.
   always_comb begin
      w_sum = {r_rem, s_if.in_bit};
      if (w_sum >= {1'b0, r_div}) begin
         w_rem_nxt = w_sum[DIV_W-1:0] - r_div;
      end else begin
         w_rem_nxt = w_sum[DIV_W-1:0];
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state logic; abort wins over a simultaneous bit
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_cfg_take) begin
               w_state_nxt = S_RUN;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RUN: begin
            if (s_if.abort) begin
               w_state_nxt = S_IDLE;
            end else if (s_if.in_valid && w_last) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RUN;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Datapath registers: config latch, running remainder, bit count, result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div     <= {DIV_W{1'b0}};
         r_len     <= {LEN_W{1'b0}};
         r_rem     <= {DIV_W{1'b0}};
         r_cnt     <= {LEN_W{1'b0}};
         r_res_rem <= {DIV_W{1'b0}};
         r_res_div <= 1'b0;
         r_err_cfg <= 1'b0;
      end else begin
         r_err_cfg <= w_cfg_bad;
         case (r_state)
            S_IDLE: begin
               if (w_cfg_take) begin
                  r_div <= s_if.cfg_divisor;
                  r_len <= s_if.cfg_len;
                  r_rem <= {DIV_W{1'b0}};
                  r_cnt <= {LEN_W{1'b0}};
               end
            end
            S_RUN: begin
               if (s_if.abort) begin
                  r_rem <= {DIV_W{1'b0}};
                  r_cnt <= {LEN_W{1'b0}};
               end else if (s_if.in_valid) begin
                  r_rem <= w_rem_nxt;
                  r_cnt <= w_cnt_nxt;
                  // Capture the result on the last bit so it is already
                  // stable during the res_valid cycle.
                  if (w_last) begin
                     r_res_rem <= w_rem_nxt;
                     r_res_div <= (w_rem_nxt == {DIV_W{1'b0}});
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // FSM output decode; cfg_ready is held low while reset is asserted
   always_comb begin
      s_if.cfg_ready = rst_n && (r_state == S_IDLE);
      s_if.in_ready  = (r_state == S_RUN);
      s_if.res_valid = (r_state == S_DONE);
      s_if.div_now   = (r_state == S_RUN) && (r_rem == {DIV_W{1'b0}});
      s_if.rem_now   = r_rem;
      s_if.res_rem   = r_res_rem;
      s_if.res_div   = r_res_div;
      s_if.err_cfg   = r_err_cfg;
   end

endmodule
